// File: rtl/uncache_axi_bridge_if.sv
// Bundle of the CPU uncached-request port and the AXI master channels seen by
// the bridge. The master modport is the bridge itself (it masters AXI and
// answers CPU requests). The slave modport is everything around it: the
// requesting CPU plus the AXI interconnect.
interface uncache_axi_bridge_if;
  // CPU request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // AXI read address / data
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  // AXI write address / data / response
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req_valid, req_wr, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arsize, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    output req_valid, req_wr, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arsize, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/uncache_axi_bridge.sv
// Uncached CPU access to single-beat AXI bridge. One transaction in flight:
// a load becomes AR then R, a store becomes AW+W (in any order) then B.
// Fixed AXI fields (id, len, burst, wlast, cache, prot) are tied off by the
// wrapper that instantiates this block.
module uncache_axi_bridge #(
  parameter logic [31:0] PA_MASK = 32'h1FFF_FFFF
) (
  input logic                  clk,
  input logic                  resetn,
  uncache_axi_bridge_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]  state_q,      state_d;
  logic [1:0]  size_q,       size_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic [3:0]  wstrb_q,      wstrb_d;
  logic        aw_done_q,    aw_done_d;
  logic        w_done_q,     w_done_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q,   resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [31:0] req_phys;

  // Byte lanes touched by an access of the given size at address offset a.
  function automatic logic [3:0] strobe_for(input logic [1:0] size,
                                            input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  // kseg0/kseg1 virtual to physical translation is a plain mask.
  assign req_phys = bus.req_addr & PA_MASK;

  // Next-state and datapath capture for the single outstanding transaction.
  always_comb begin
    // NOTE: every _d starts as its _q (resp_valid as 0) so no branch can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          size_d    = bus.req_size;
          addr_d    = req_phys;
          wdata_d   = bus.req_wdata;
          wstrb_d   = strobe_for(bus.req_size, req_phys[1:0]);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.req_wr ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (bus.arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (bus.rvalid) begin
          resp_rdata_d = bus.rdata;
          resp_err_d   = bus.rresp[1];
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // Each valid is high exactly while its done flag is clear, so ready
        // alone marks the handshake; both may land in the same cycle.
        aw_done_d = aw_done_q | bus.awready;
        w_done_d  = w_done_q  | bus.wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bus.bvalid) begin
          resp_err_d   = bus.bresp[1];
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers.
  // NOTE: the AXI valids and readies are decoded from state_q only, so the
  // asynchronous reset forcing IDLE drops them immediately, mid-cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q      <= state_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign bus.araddr  = addr_q;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arvalid = (state_q == S_RD_ADDR);
  assign bus.rready  = (state_q == S_RD_DATA);

  assign bus.awaddr  = addr_q;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign bus.bready  = (state_q == S_WR_RESP);

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Bench for uncache_axi_bridge: directed scenarios with literal expectations,
// then randomized CPU/AXI traffic, all checked every cycle against a
// transaction-level model of the bridge.
module tb_uncache_axi_bridge;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  uncache_axi_bridge_if bus ();

  uncache_axi_bridge #(.PA_MASK(32'h1FFF_FFFF)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_resp_rand = 0;
  bit rand_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One pending access; its progress is a set of "channel finished" flags.
  logic        m_busy = 0, m_wr = 0;
  logic        m_ar_done = 0, m_aw_done = 0, m_w_done = 0;
  logic        m_rv = 0, m_err = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_strb = 0;

  function automatic logic [3:0] lanes(input logic [1:0] size,
                                       input logic [31:0] a);
    int unsigned off = a % 4;
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_wr = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
      m_rv = 0; m_err = 0; m_size = 0; m_addr = 0; m_wdata = 0;
      m_rdata = 0; m_strb = 0;
    end else begin
      m_rv = 0;
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy = 1; m_wr = bus.req_wr; m_size = bus.req_size;
          m_addr = bus.req_addr & 32'h1FFF_FFFF; m_wdata = bus.req_wdata;
          m_strb = lanes(m_size, m_addr);
          m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
        end
      end else if (!m_wr) begin
        if (!m_ar_done) m_ar_done = bus.arready;
        else if (bus.rvalid) begin
          m_rdata = bus.rdata; m_err = bus.rresp[1]; m_rv = 1; m_busy = 0;
        end
      end else begin
        if (m_aw_done && m_w_done) begin
          if (bus.bvalid) begin m_err = bus.bresp[1]; m_rv = 1; m_busy = 0; end
        end else begin
          if (bus.awready) m_aw_done = 1;
          if (bus.wready)  m_w_done  = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("req_ready",  32'(bus.req_ready),  32'(!m_busy));
    check("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
    check("resp_err",   32'(bus.resp_err),   32'(m_err));
    check("resp_rdata", bus.resp_rdata,      m_rdata);
    check("arvalid", 32'(bus.arvalid), 32'(m_busy && !m_wr && !m_ar_done));
    check("rready",  32'(bus.rready),  32'(m_busy && !m_wr && m_ar_done));
    check("awvalid", 32'(bus.awvalid), 32'(m_busy && m_wr && !m_aw_done));
    check("wvalid",  32'(bus.wvalid),  32'(m_busy && m_wr && !m_w_done));
    check("bready",  32'(bus.bready),  32'(m_busy && m_wr && m_aw_done && m_w_done));
    if (m_busy && !m_wr) begin
      check("araddr", bus.araddr, m_addr);
      check("arsize", 32'(bus.arsize), 32'({1'b0, m_size}));
    end
    if (m_busy && m_wr) begin
      check("awaddr", bus.awaddr, m_addr);
      check("awsize", 32'(bus.awsize), 32'({1'b0, m_size}));
      check("wdata",  bus.wdata, m_wdata);
      check("wstrb",  32'(bus.wstrb), 32'(m_strb));
    end
    if (rand_phase && bus.resp_valid) n_resp_rand++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_size = size;
    bus.req_addr = addr; bus.req_wdata = wd;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_wr = 0; bus.req_size = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;

    // Reset values
    repeat (3) step();
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_arvalid",    32'(bus.arvalid), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_wstrb",      32'(bus.wstrb), 32'd0);
    check("rst_araddr",     bus.araddr, 32'd0);
    resetn = 1'b1;
    step();

    // Load word, minimum latency
    req(1'b0, 2'd2, 32'hBFC0_0010, 32'd0);
    bus.arready = 1;
    step();
    bus.req_valid = 0;
    check("ld_arvalid", 32'(bus.arvalid), 32'd1);
    check("ld_araddr",  bus.araddr, 32'h1FC0_0010);
    check("ld_arsize",  32'(bus.arsize), 32'd2);
    check("ld_req_ready_busy", 32'(bus.req_ready), 32'd0);
    bus.rvalid = 1; bus.rdata = 32'h1234_5678; bus.rresp = 2'b00;
    step();
    check("ld_rready", 32'(bus.rready), 32'd1);
    step();
    check("ld_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("ld_resp_rdata", bus.resp_rdata, 32'h1234_5678);
    check("ld_resp_err",   32'(bus.resp_err), 32'd0);
    check("ld_req_ready_again", 32'(bus.req_ready), 32'd1);
    bus.rvalid = 0; bus.arready = 0;
    step();
    check("ld_resp_pulse_once", 32'(bus.resp_valid), 32'd0);

    // Store byte, W handshake before AW
    req(1'b1, 2'd0, 32'hA000_0003, 32'hAB00_0000);
    step();
    bus.req_valid = 0;
    check("sb_awvalid", 32'(bus.awvalid), 32'd1);
    check("sb_wvalid",  32'(bus.wvalid), 32'd1);
    check("sb_wstrb",   32'(bus.wstrb), 32'h8);
    check("sb_awaddr",  bus.awaddr, 32'h0000_0003);
    check("sb_wdata",   bus.wdata, 32'hAB00_0000);
    bus.wready = 1;
    step();
    check("sb_wvalid_dropped", 32'(bus.wvalid), 32'd0);
    check("sb_awvalid_held",   32'(bus.awvalid), 32'd1);
    check("sb_no_bready_yet",  32'(bus.bready), 32'd0);
    bus.wready = 0; bus.awready = 1;
    step();
    check("sb_awvalid_dropped", 32'(bus.awvalid), 32'd0);
    check("sb_bready", 32'(bus.bready), 32'd1);
    bus.awready = 0; bus.bvalid = 1; bus.bresp = 2'b00;
    step();
    check("sb_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("sb_resp_err",   32'(bus.resp_err), 32'd0);
    check("sb_rdata_kept", bus.resp_rdata, 32'h1234_5678);
    bus.bvalid = 0;
    step();

    // Store half with SLVERR, AW and W in the same cycle
    req(1'b1, 2'd1, 32'hA000_0002, 32'hCDEF_0000);
    bus.awready = 1; bus.wready = 1;
    step();
    bus.req_valid = 0;
    check("sh_wstrb", 32'(bus.wstrb), 32'hC);
    step();
    check("sh_bready",  32'(bus.bready), 32'd1);
    check("sh_awvalid", 32'(bus.awvalid), 32'd0);
    bus.awready = 0; bus.wready = 0; bus.bvalid = 1; bus.bresp = 2'b10;
    step();
    check("sh_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("sh_resp_err",   32'(bus.resp_err), 32'd1);
    bus.bvalid = 0; bus.bresp = 2'b00;
    step();

    // AR stall for 5 cycles; a second request during the stall is ignored
    req(1'b0, 2'd2, 32'h8000_0100, 32'd0);
    step();
    bus.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid",   32'(bus.arvalid), 32'd1);
      check("stall_araddr",    bus.araddr, 32'h0000_0100);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      if (i == 1) req(1'b1, 2'd0, 32'hA000_0FF0, 32'h1111_2222);
      if (i == 3) bus.req_valid = 0;
      step();
    end
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D; bus.rresp = 2'b11;
    step();
    check("stall_rready", 32'(bus.rready), 32'd1);
    step();
    check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("stall_resp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
    check("stall_resp_err",   32'(bus.resp_err), 32'd1);
    check("stall_no_write",   32'(bus.awvalid), 32'd0);
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 2'b00;
    step();

    // Reset pulse while waiting for R data
    req(1'b0, 2'd2, 32'hBFC0_0020, 32'd0);
    bus.arready = 1;
    step();
    bus.req_valid = 0;
    step();
    check("rst_mid_rready_before", 32'(bus.rready), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_mid_rready",  32'(bus.rready), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    resetn = 1'b1;
    check("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
    step();
    req(1'b0, 2'd2, 32'h9FC0_0040, 32'd0);
    bus.rvalid = 1; bus.rdata = 32'h0BAD_BEEF; bus.rresp = 2'b00;
    step();
    bus.req_valid = 0;
    step();
    step();
    check("rst_after_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("rst_after_resp_rdata", bus.resp_rdata, 32'h0BAD_BEEF);
    bus.arready = 0; bus.rvalid = 0;
    step();

    // Randomized traffic
    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = ($urandom % 3) == 0;
      bus.req_wr    = 1'($urandom);
      bus.req_size  = 2'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.arready   = 1'($urandom);
      bus.rvalid    = 1'($urandom);
      bus.rdata     = $urandom;
      bus.rresp     = 2'($urandom);
      bus.awready   = 1'($urandom);
      bus.wready    = 1'($urandom);
      bus.bvalid    = 1'($urandom);
      bus.bresp     = 2'($urandom);
      if (c == 1500) begin
        #1 resetn = 1'b0;
      end
      if (c == 1502) resetn = 1'b1;
      step();
    end
    rand_phase = 1'b0;
    check("rand_resp_seen", 32'(n_resp_rand > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
